as_rv32i_exit_monitor: RTL and testbench
========================================

Name: as_rv32i_exit_monitor

Overview:
Synthesizable run-control and exit checker for the RV32I core, driven by the core's retirement stream. It counts retired instructions, cycles and traps, and halts the run on a mode-selected condition (ecall, ebreak or illegal instruction) or on a watchdog timeout. After the halt it evaluates the riscv-tests exit convention (a7 == 0x5d, a0 == 0 means pass). It sits beside as_rv32i_soc in FPGA and simulation builds, so a self-checking verdict is available on pins and in simulation without testbench-side hierarchical probing.

Parameters:
HALT_MODE, 0, halt condition: 0 = ecall or ebreak, 1 = ebreak only, 2 = ecall only, 3 = illegal instruction only
EXIT_MAGIC, 32'h5d, required a7 (x17) value for a valid exit
CNT_WIDTH, 32, width of the instret, cycle and trap counters
TIMEOUT_CYCLES, 10000, total-cycle watchdog limit; 0 disables it
STALL_LIMIT, 1024, maximum consecutive cycles with no retirement; 0 disables it
DRAIN_CYCLES, 2, cycles waited after the halt before a0/a7 are sampled (must be >= 1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_retire_valid  in  1  one instruction retires this cycle
i_retire_pc  in  32  PC of the retiring instruction
i_is_ecall  in  1  retiring instruction is ecall (qualified by i_retire_valid)
i_is_ebreak  in  1  retiring instruction is ebreak (qualified by i_retire_valid)
i_is_illegal  in  1  retiring instruction is illegal (qualified by i_retire_valid)
i_trap_taken  in  1  core enters a trap this cycle
i_a0  in  32  live base register x10
i_a7  in  32  live base register x17
o_halt  out  1  halt request to the core (hold pipeline)
o_done  out  1  verdict valid
o_pass  out  1  a7 == EXIT_MAGIC and a0 == 0
o_fail  out  1  a7 == EXIT_MAGIC and a0 != 0
o_unknown  out  1  a7 != EXIT_MAGIC
o_timeout  out  1  run ended by a watchdog
o_exit_code  out  31  a0[31:1]
o_halt_pc  out  32  PC of the halting instruction
o_instret  out  CNT_WIDTH  retired-instruction count
o_cycles  out  CNT_WIDTH  cycle count since reset release
o_traps  out  CNT_WIDTH  traps taken

Behaviour:
- Reset (asynchronous): state RUN; all outputs and counters 0.
- States: RUN, DRAIN, DONE. The encoding is internal.
- RUN:
  - o_cycles increments every cycle.
  - o_instret increments on i_retire_valid.
  - o_traps increments on i_trap_taken.
  - All counters saturate at all-ones and never wrap.
- Halt match: i_retire_valid together with the HALT_MODE-selected flag.
  - On a match: capture i_retire_pc into o_halt_pc, assert o_halt from the next cycle, go to DRAIN.
  - The halting instruction is counted in o_instret.
- Stall counter: cleared on every retire, incremented otherwise.
- Watchdog trips in RUN when o_cycles == TIMEOUT_CYCLES-1 or the stall counter == STALL_LIMIT-1 (each only if its parameter is nonzero).
  - On a trip: o_timeout = 1, o_halt = 1, o_halt_pc = 0, go to DRAIN.
- A halt match and a watchdog trip in the same cycle: the halt match wins and o_timeout stays 0.
- DRAIN:
  - Counters freeze.
  - Wait exactly DRAIN_CYCLES cycles, then sample i_a0/i_a7 and enter DONE.
  - Retire and trap inputs are ignored.
- DONE verdict:
  - o_done = 1.
  - Exactly one of o_pass, o_fail, o_unknown is 1.
  - o_exit_code = a0 >> 1.
  - On a timeout the verdict is still evaluated, with o_timeout = 1 alongside it.
- DONE is terminal until reset. Outputs are stable and all inputs are ignored.
- Reset asserted in any state returns the block to the reset values immediately. No verdict survives a reset.
- All outputs are registered, with no combinational input-to-output paths.

Test Plan:
- HALT_MODE=0: retire 10 instructions, then ecall at PC 0x40 with a7=0x5d, a0=0 -> o_instret=11, o_halt_pc=0x40, o_done exactly 2 cycles after the halt, o_pass=1.
- HALT_MODE=1: ecall retires (no halt), then ebreak with a7=0x5d, a0=0x7 -> o_fail=1, o_exit_code=3.
- HALT_MODE=0: halt with a7=0x10 -> o_unknown=1, o_pass=0, o_fail=0.
- STALL_LIMIT=8: no retires after reset -> o_timeout=1 at cycle 8, o_halt_pc=0.
- TIMEOUT_CYCLES=20: retire every cycle -> timeout at o_cycles=19. Repeat with an ecall in cycle 19 -> halt match wins, o_timeout=0.
- Reset in DRAIN and again in DONE -> all outputs 0 asynchronously; the next run produces a fresh verdict. Force counters near all-ones -> they saturate.

Source files
------------

// File: rtl/as_rv32i_exit_monitor.sv
// Run-control and exit checker for the RV32I core.
// Watches the retirement stream, counts instructions, cycles and traps, and
// stops the run on a selected halt instruction or a watchdog timeout. After a
// short drain it samples a0/a7 and publishes a pass/fail/unknown verdict.
module as_rv32i_exit_monitor #(
   parameter int          HALT_MODE      = 0,
   parameter logic [31:0] EXIT_MAGIC     = 32'h0000_005d,
   parameter int          CNT_WIDTH      = 32,
   parameter int          TIMEOUT_CYCLES = 10000,
   parameter int          STALL_LIMIT    = 1024,
   parameter int          DRAIN_CYCLES   = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_retire_valid,
   input  logic [31:0]          i_retire_pc,
   input  logic                 i_is_ecall,
   input  logic                 i_is_ebreak,
   input  logic                 i_is_illegal,
   input  logic                 i_trap_taken,
   input  logic [31:0]          i_a0,
   input  logic [31:0]          i_a7,
   output logic                 o_halt,
   output logic                 o_done,
   output logic                 o_pass,
   output logic                 o_fail,
   output logic                 o_unknown,
   output logic                 o_timeout,
   output logic [30:0]          o_exit_code,
   output logic [31:0]          o_halt_pc,
   output logic [CNT_WIDTH-1:0] o_instret,
   output logic [CNT_WIDTH-1:0] o_cycles,
   output logic [CNT_WIDTH-1:0] o_traps
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [1:0]           MODE       = 2'(HALT_MODE);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] STALL_LAST = CNT_WIDTH'(STALL_LIMIT - 1);
   localparam logic [15:0]          DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
   localparam bit                   TO_EN      = (TIMEOUT_CYCLES != 0);
   localparam bit                   STALL_EN   = (STALL_LIMIT != 0);

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   logic [1:0]           state_q, state_d;
   logic [15:0]          drain_q, drain_d;
   logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;
   logic [CNT_WIDTH-1:0] traps_q, traps_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;
   logic                 halt_q, halt_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;
   logic                 unknown_q, unknown_d;
   logic                 timeout_q, timeout_d;
   logic [30:0]          exit_code_q, exit_code_d;
   logic [31:0]          halt_pc_q, halt_pc_d;
   logic                 halt_flag_s;
   logic                 halt_match_s;
   logic                 trip_s;

   // Select which retiring instruction class ends the run.
   always_comb begin
      halt_flag_s = 1'b0;
      case (MODE)
         2'd0:    halt_flag_s = i_is_ecall | i_is_ebreak;
         2'd1:    halt_flag_s = i_is_ebreak;
         2'd2:    halt_flag_s = i_is_ecall;
         2'd3:    halt_flag_s = i_is_illegal;
         default: halt_flag_s = 1'b0;
      endcase
      halt_match_s = i_retire_valid & halt_flag_s;
      trip_s = (TO_EN && (cycles_q == TO_LAST)) || (STALL_EN && (stall_q == STALL_LAST));
   end

   // Next-state logic: counting in RUN, drain countdown, verdict capture.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      cycles_d    = cycles_q;
      instret_d   = instret_q;
      traps_d     = traps_q;
      stall_d     = stall_q;
      halt_d      = halt_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      unknown_d   = unknown_q;
      timeout_d   = timeout_q;
      exit_code_d = exit_code_q;
      halt_pc_d   = halt_pc_q;
      case (state_q)
         ST_RUN: begin
            cycles_d = sat_inc(cycles_q);
            if (i_retire_valid) begin
               instret_d = sat_inc(instret_q);
               stall_d   = CNT_ZERO;
            end else begin
               stall_d   = sat_inc(stall_q);
            end
            if (i_trap_taken) begin
               traps_d = sat_inc(traps_q);
            end else begin
               traps_d = traps_q;
            end
            // A real halt instruction outranks a simultaneous watchdog trip.
            if (halt_match_s) begin
               halt_d    = 1'b1;
               halt_pc_d = i_retire_pc;
               drain_d   = 16'd0;
               state_d   = ST_DRAIN;
            end else if (trip_s) begin
               halt_d    = 1'b1;
               timeout_d = 1'b1;
               halt_pc_d = 32'd0;
               drain_d   = 16'd0;
               state_d   = ST_DRAIN;
            end else begin
               state_d   = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Give in-flight register writes time to land before sampling a0/a7.
            if (drain_q == DRAIN_LAST) begin
               done_d      = 1'b1;
               pass_d      = (i_a7 == EXIT_MAGIC) && (i_a0 == 32'd0);
               fail_d      = (i_a7 == EXIT_MAGIC) && (i_a0 != 32'd0);
               unknown_d   = (i_a7 != EXIT_MAGIC);
               exit_code_d = i_a0[31:1];
               state_d     = ST_DONE;
            end else begin
               drain_d     = drain_q + 16'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_RUN;
         drain_q     <= 16'd0;
         cycles_q    <= CNT_ZERO;
         instret_q   <= CNT_ZERO;
         traps_q     <= CNT_ZERO;
         stall_q     <= CNT_ZERO;
         halt_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         unknown_q   <= 1'b0;
         timeout_q   <= 1'b0;
         exit_code_q <= 31'd0;
         halt_pc_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         cycles_q    <= cycles_d;
         instret_q   <= instret_d;
         traps_q     <= traps_d;
         stall_q     <= stall_d;
         halt_q      <= halt_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         unknown_q   <= unknown_d;
         timeout_q   <= timeout_d;
         exit_code_q <= exit_code_d;
         halt_pc_q   <= halt_pc_d;
      end
   end

   assign o_halt      = halt_q;
   assign o_done      = done_q;
   assign o_pass      = pass_q;
   assign o_fail      = fail_q;
   assign o_unknown   = unknown_q;
   assign o_timeout   = timeout_q;
   assign o_exit_code = exit_code_q;
   assign o_halt_pc   = halt_pc_q;
   assign o_instret   = instret_q;
   assign o_cycles    = cycles_q;
   assign o_traps     = traps_q;

endmodule

// File: tb/tb_as_rv32i_exit_monitor.sv
// Bench for as_rv32i_exit_monitor: several parameterisations share one
// stimulus stream; results are compared to constants and to a trace-based model.
module tb_as_rv32i_exit_monitor;

   localparam int NI = 6;
   localparam int MODE_P [NI] = '{0, 1, 0, 0, 3, 2};
   localparam int TO_P   [NI] = '{300, 10000, 0, 20, 0, 0};
   localparam int SL_P   [NI] = '{16, 1024, 8, 0, 0, 5};
   localparam int CW_P   [NI] = '{32, 32, 32, 32, 4, 32};
   localparam int DR_P   [NI] = '{2, 2, 2, 2, 1, 3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        ret = 1'b0, ec = 1'b0, eb = 1'b0, il = 1'b0, trap = 1'b0;
   logic [31:0] pc = 32'd0, a0 = 32'd0, a7 = 32'd0;

   logic        halt_a [NI];
   logic        done_a [NI];
   logic        pass_a [NI];
   logic        fail_a [NI];
   logic        unk_a  [NI];
   logic        to_a   [NI];
   logic [30:0] code_a [NI];
   logic [31:0] hpc_a  [NI];
   logic [31:0] inst_a [NI];
   logic [31:0] cyc_a  [NI];
   logic [31:0] trp_a  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [CW_P[g]-1:0] inst_s, cyc_s, trp_s;
      as_rv32i_exit_monitor #(
         .HALT_MODE(MODE_P[g]), .EXIT_MAGIC(32'h5d), .CNT_WIDTH(CW_P[g]),
         .TIMEOUT_CYCLES(TO_P[g]), .STALL_LIMIT(SL_P[g]), .DRAIN_CYCLES(DR_P[g])
      ) u_dut (
         .i_clk(clk), .i_rst(rst), .i_retire_valid(ret), .i_retire_pc(pc),
         .i_is_ecall(ec), .i_is_ebreak(eb), .i_is_illegal(il), .i_trap_taken(trap),
         .i_a0(a0), .i_a7(a7),
         .o_halt(halt_a[g]), .o_done(done_a[g]), .o_pass(pass_a[g]), .o_fail(fail_a[g]),
         .o_unknown(unk_a[g]), .o_timeout(to_a[g]), .o_exit_code(code_a[g]),
         .o_halt_pc(hpc_a[g]), .o_instret(inst_s), .o_cycles(cyc_s), .o_traps(trp_s)
      );
      assign inst_a[g] = 32'(inst_s);
      assign cyc_a[g]  = 32'(cyc_s);
      assign trp_a[g]  = 32'(trp_s);
   end

   // Trace of every cycle's inputs since the last reset release.
   bit          q_ret[$], q_ec[$], q_eb[$], q_il[$], q_tr[$];
   logic [31:0] q_pc[$], q_a0[$], q_a7[$];

   int checks = 0;
   int failures = 0;

   typedef struct {
      int          g;
      int          pre;
      int          ka;
      int          kb;
      logic [31:0] pca;
      logic [31:0] a0v;
      logic [31:0] a7v;
      int          tail;
      logic        xpass, xfail, xunk, xto;
      logic [30:0] xcode;
      logic [31:0] xpc, xinst, xcyc;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit e_c, input bit e_b, input bit i_l,
                       input bit t, input logic [31:0] p);
      ret = r; ec = e_c; eb = e_b; il = i_l; trap = t; pc = p;
      q_ret.push_back(r); q_ec.push_back(e_c); q_eb.push_back(e_b); q_il.push_back(i_l);
      q_tr.push_back(t); q_pc.push_back(p); q_a0.push_back(a0); q_a7.push_back(a7);
      @(posedge clk);
      @(negedge clk);
   endtask

   // kind: 1 plain retire, 2 ecall, 3 ebreak, 4 illegal
   task automatic kind_step(input int k, input logic [31:0] p);
      step(1'b1, k == 2, k == 3, k == 4, 1'b0, p);
   endtask

   task automatic release_rst();
      @(negedge clk);
      q_ret.delete(); q_ec.delete(); q_eb.delete(); q_il.delete();
      q_tr.delete(); q_pc.delete(); q_a0.delete(); q_a7.delete();
      rst = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ret = 1'b0; ec = 1'b0; eb = 1'b0; il = 1'b0; trap = 1'b0; pc = 32'd0;
      release_rst();
   endtask

   // Reference: find the first cycle that ends the run, then derive every output.
   task automatic check_inst(input int g, input string tag);
      longint maxv = (64'd1 << CW_P[g]) - 1;
      int n = q_ret.size();
      int h = -1;
      int idle = 0;
      int end_c;
      longint ni = 0, nt = 0, cyc;
      bit is_to = 1'b0, fl, m, trip, xdone, xp = 1'b0, xf = 1'b0, xu = 1'b0;
      logic [30:0] xc = 31'd0;
      logic [31:0] xhpc = 32'd0;
      for (int c = 0; c < n; c++) begin
         case (MODE_P[g])
            0:       fl = q_ec[c] | q_eb[c];
            1:       fl = q_eb[c];
            2:       fl = q_ec[c];
            default: fl = q_il[c];
         endcase
         m = q_ret[c] && fl;
         cyc = (c > maxv) ? maxv : longint'(c);
         trip = (TO_P[g] != 0 && cyc == longint'(TO_P[g] - 1)) ||
                (SL_P[g] != 0 && idle == SL_P[g] - 1);
         if (m || trip) begin
            h = c;
            is_to = !m;
            if (m) xhpc = q_pc[c];
            break;
         end
         idle = q_ret[c] ? 0 : idle + 1;
      end
      end_c = (h >= 0) ? h + 1 : n;
      for (int c = 0; c < end_c; c++) begin
         ni += q_ret[c];
         nt += q_tr[c];
      end
      if (ni > maxv) ni = maxv;
      if (nt > maxv) nt = maxv;
      cyc = (end_c > maxv) ? maxv : longint'(end_c);
      xdone = (h >= 0) && (n >= h + 1 + DR_P[g]);
      if (xdone) begin
         xp = (q_a7[h + DR_P[g]] == 32'h5d) && (q_a0[h + DR_P[g]] == 32'd0);
         xf = (q_a7[h + DR_P[g]] == 32'h5d) && (q_a0[h + DR_P[g]] != 32'd0);
         xu = (q_a7[h + DR_P[g]] != 32'h5d);
         xc = q_a0[h + DR_P[g]][31:1];
      end
      chk($sformatf("%s/u%0d halt", tag, g),    32'(halt_a[g]), 32'(h >= 0));
      chk($sformatf("%s/u%0d timeout", tag, g), 32'(to_a[g]),   32'((h >= 0) && is_to));
      chk($sformatf("%s/u%0d done", tag, g),    32'(done_a[g]), 32'(xdone));
      chk($sformatf("%s/u%0d pass", tag, g),    32'(pass_a[g]), 32'(xp));
      chk($sformatf("%s/u%0d fail", tag, g),    32'(fail_a[g]), 32'(xf));
      chk($sformatf("%s/u%0d unknown", tag, g), 32'(unk_a[g]),  32'(xu));
      chk($sformatf("%s/u%0d exit_code", tag, g), 32'(code_a[g]), 32'(xc));
      chk($sformatf("%s/u%0d halt_pc", tag, g), hpc_a[g],  xhpc);
      chk($sformatf("%s/u%0d instret", tag, g), inst_a[g], 32'(ni));
      chk($sformatf("%s/u%0d cycles", tag, g),  cyc_a[g],  32'(cyc));
      chk($sformatf("%s/u%0d traps", tag, g),   trp_a[g],  32'(nt));
   endtask

   task automatic check_all(input string tag);
      for (int g = 0; g < NI; g++) check_inst(g, tag);
   endtask

   initial begin
      //           g pre ka kb pca        a0           a7     tail pass fail unk to  code          pc          inst cyc
      vecs[0] = '{0, 10, 2, 0, 32'h40,   32'h0,        32'h5d, 4, 1'b1, 1'b0, 1'b0, 1'b0, 31'd0,  32'h40,    32'd11, 32'd11};
      vecs[1] = '{1, 3,  2, 3, 32'h100,  32'h7,        32'h5d, 4, 1'b0, 1'b1, 1'b0, 1'b0, 31'd3,  32'h104,   32'd5,  32'd5};
      vecs[2] = '{0, 2,  3, 0, 32'h80,   32'h0,        32'h10, 4, 1'b0, 1'b0, 1'b1, 1'b0, 31'd0,  32'h80,    32'd3,  32'd3};
      vecs[3] = '{2, 0,  0, 0, 32'h0,    32'h0,        32'h5d, 12, 1'b1, 1'b0, 1'b0, 1'b1, 31'd0, 32'h0,     32'd0,  32'd8};
      vecs[4] = '{5, 1,  3, 2, 32'h20,   32'h2,        32'h5d, 6, 1'b0, 1'b1, 1'b0, 1'b0, 31'd1,  32'h24,    32'd3,  32'd3};
      vecs[5] = '{4, 3,  2, 4, 32'h10,   32'h0,        32'h5d, 3, 1'b1, 1'b0, 1'b0, 1'b0, 31'd0,  32'h14,    32'd5,  32'd5};
      vecs[6] = '{3, 25, 0, 0, 32'h0,    32'h4,        32'h5d, 3, 1'b0, 1'b1, 1'b0, 1'b1, 31'd2,  32'h0,     32'd20, 32'd20};
      vecs[7] = '{0, 0,  2, 0, 32'hABC0, 32'hFFFF_FFFF, 32'h5c, 3, 1'b0, 1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'hABC0, 32'd1, 32'd1};

      // reset state
      #2;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("reset/u%0d halt", g), 32'(halt_a[g]), 32'd0);
         chk($sformatf("reset/u%0d done", g), 32'(done_a[g]), 32'd0);
         chk($sformatf("reset/u%0d cycles", g), cyc_a[g], 32'd0);
      end
      @(negedge clk);
      do_reset();

      // table-driven scenarios
      for (int v = 0; v < 8; v++) begin
         do_reset();
         a0 = vecs[v].a0v;
         a7 = vecs[v].a7v;
         for (int i = 0; i < vecs[v].pre; i++) kind_step(1, 32'(4 * i));
         if (vecs[v].ka != 0) kind_step(vecs[v].ka, vecs[v].pca);
         if (vecs[v].kb != 0) kind_step(vecs[v].kb, vecs[v].pca + 32'd4);
         for (int i = 0; i < vecs[v].tail; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
         chk($sformatf("vec%0d done", v),    32'(done_a[vecs[v].g]), 32'd1);
         chk($sformatf("vec%0d halt", v),    32'(halt_a[vecs[v].g]), 32'd1);
         chk($sformatf("vec%0d pass", v),    32'(pass_a[vecs[v].g]), 32'(vecs[v].xpass));
         chk($sformatf("vec%0d fail", v),    32'(fail_a[vecs[v].g]), 32'(vecs[v].xfail));
         chk($sformatf("vec%0d unknown", v), 32'(unk_a[vecs[v].g]),  32'(vecs[v].xunk));
         chk($sformatf("vec%0d timeout", v), 32'(to_a[vecs[v].g]),   32'(vecs[v].xto));
         chk($sformatf("vec%0d code", v),    32'(code_a[vecs[v].g]), 32'(vecs[v].xcode));
         chk($sformatf("vec%0d halt_pc", v), hpc_a[vecs[v].g],  vecs[v].xpc);
         chk($sformatf("vec%0d instret", v), inst_a[vecs[v].g], vecs[v].xinst);
         chk($sformatf("vec%0d cycles", v),  cyc_a[vecs[v].g],  vecs[v].xcyc);
         check_all($sformatf("vec%0d", v));
      end

      // verdict arrives exactly two cycles after the halt
      do_reset();
      a0 = 32'd0; a7 = 32'h5d;
      for (int i = 0; i < 10; i++) kind_step(1, 32'(4 * i));
      kind_step(2, 32'h40);
      chk("lat halt+0 halt", 32'(halt_a[0]), 32'd1);
      chk("lat halt+0 done", 32'(done_a[0]), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44);
      chk("lat halt+1 done", 32'(done_a[0]), 32'd0);
      chk("lat drain instret frozen", inst_a[0], 32'd11);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("lat halt+2 done", 32'(done_a[0]), 32'd1);
      chk("lat halt+2 pass", 32'(pass_a[0]), 32'd1);
      check_all("lat");

      // ecall in the watchdog's last cycle: halt wins
      do_reset();
      a0 = 32'd0; a7 = 32'h5d;
      for (int i = 0; i < 19; i++) kind_step(1, 32'(4 * i));
      kind_step(2, 32'h4C);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("win timeout", 32'(to_a[3]), 32'd0);
      chk("win halt_pc", hpc_a[3], 32'h4C);
      chk("win pass", 32'(pass_a[3]), 32'd1);
      chk("win instret", inst_a[3], 32'd20);
      check_all("win");

      // asynchronous reset during DRAIN, then a fresh run
      do_reset();
      a0 = 32'd0; a7 = 32'h5d;
      for (int i = 0; i < 3; i++) kind_step(1, 32'(4 * i));
      kind_step(2, 32'h8);
      chk("drain pre-rst halt", 32'(halt_a[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst-drain halt", 32'(halt_a[0]), 32'd0);
      chk("rst-drain instret", inst_a[0], 32'd0);
      chk("rst-drain cycles", cyc_a[0], 32'd0);
      chk("rst-drain halt_pc", hpc_a[0], 32'd0);
      release_rst();
      a0 = 32'd6;
      kind_step(1, 32'h2C);
      kind_step(2, 32'h30);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("rerun fail", 32'(fail_a[0]), 32'd1);
      chk("rerun code", 32'(code_a[0]), 32'd3);
      check_all("rerun");

      // asynchronous reset in DONE clears the verdict
      rst = 1'b1;
      #1;
      chk("rst-done done", 32'(done_a[0]), 32'd0);
      chk("rst-done fail", 32'(fail_a[0]), 32'd0);
      chk("rst-done code", 32'(code_a[0]), 32'd0);
      chk("rst-done halt", 32'(halt_a[0]), 32'd0);
      release_rst();
      a0 = 32'd0;
      kind_step(3, 32'h60);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("rerun2 pass", 32'(pass_a[0]), 32'd1);
      chk("rerun2 halt_pc", hpc_a[0], 32'h60);

      // 4-bit counters saturate at 15
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'(4 * i));
      chk("sat instret", inst_a[4], 32'd15);
      chk("sat cycles", cyc_a[4], 32'd15);
      chk("sat traps", trp_a[4], 32'd15);
      check_all("sat");

      // randomized runs against the trace model
      for (int run = 0; run < 40; run++) begin
         int pr, n, x;
         do_reset();
         pr = $urandom_range(30, 100);
         n  = $urandom_range(5, 70);
         for (int i = 0; i < n; i++) begin
            x  = $urandom_range(0, 99);
            a7 = ($urandom_range(0, 3) == 0) ? $urandom : 32'h5d;
            a0 = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            step($urandom_range(1, 100) <= pr, x < 4, x >= 4 && x < 8, x >= 8 && x < 11,
                 $urandom_range(0, 9) == 0, $urandom);
         end
         check_all($sformatf("rnd%0d", run));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
